// File: rtl/mac_accum_pkg.sv
// mac_accum_pkg: shared types and constants for the MAC accumulator slice.
//   state_t   : accumulator FSM states (IDLE / ACCUM / HOLD)
//   P_W       : width of the unsigned 8x8 product feeding the accumulator
//   ACC_W_DEF : default accumulator / result width
//   LEN_W_DEF : default width of the group-length input
package mac_accum_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int P_W       = 16;
  localparam int ACC_W_DEF = 32;
  localparam int LEN_W_DEF = 8;

endpackage

// File: rtl/mac_accum_if.sv
// mac_accum_if: product-in / result-out handshake bundle of mac_accum.
//   len, p_in, in_valid, in_ready     : product stream (ready/valid)
//   acc_out, ovf, out_valid, out_ready: completed-group result (ready/valid)
//   master : producer / consumer side (testbench or surrounding logic)
//   slave  : the accumulator itself
interface mac_accum_if
  import mac_accum_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int LEN_W = LEN_W_DEF
);

  logic [LEN_W-1:0] len;
  logic [P_W-1:0]   p_in;
  logic             in_valid;
  logic             in_ready;
  logic [ACC_W-1:0] acc_out;
  logic             ovf;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output len, p_in, in_valid, out_ready,
    input  in_ready, acc_out, ovf, out_valid
  );

  modport slave (
    input  len, p_in, in_valid, out_ready,
    output in_ready, acc_out, ovf, out_valid
  );

endinterface

// File: rtl/mac_acc_add.sv
// mac_acc_add: accumulator adder with carry-out.
//   a     : current accumulator value (ACC_W)
//   b     : unsigned product, zero-extended to ACC_W
//   sum   : a + b, wrapped modulo 2^ACC_W, or clamped to all-ones on carry
//           when MAC_ACCUM_SAT_EN is defined
//   carry : carry out of bit ACC_W-1
// Configuration macro: MAC_ACCUM_SAT_EN (saturating accumulate).
module mac_acc_add
  import mac_accum_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic [ACC_W-1:0] a,
  input  logic [P_W-1:0]   b,
  output logic [ACC_W-1:0] sum,
  output logic             carry
);

  logic [ACC_W:0] full_s;

  // one bit wider than the accumulator so the carry is visible
  always_comb begin
    full_s = {1'b0, a} + {{(ACC_W - P_W + 1){1'b0}}, b};
    carry  = full_s[ACC_W];
`ifdef MAC_ACCUM_SAT_EN
    // once clamped, any further non-zero product carries again, so the
    // accumulator stays pinned at all-ones for the rest of the group
    if (full_s[ACC_W]) begin
      sum = {ACC_W{1'b1}};
    end else begin
      sum = full_s[ACC_W-1:0];
    end
`else
    sum = full_s[ACC_W-1:0];
`endif
  end

endmodule

// File: rtl/mac_accum.sv
// mac_accum: sums groups of len unsigned 16-bit products and presents each
// group total with a sticky overflow flag.
//   clk   : single clock, rising edge
//   rst_n : synchronous active-low reset
//   clr   : synchronous abort of the current group (beats that cycle dropped)
//   bus   : mac_accum_if.slave -- len/p_in/in_valid/in_ready product stream,
//           acc_out/ovf/out_valid/out_ready result handshake
// Configuration macro: MAC_ACCUM_SAT_EN (saturate instead of wrap on overflow,
// implemented inside mac_acc_add).
module mac_accum
  import mac_accum_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  mac_accum_if.slave bus
);

  state_t           state_r;
  state_t           state_nx_s;
  logic             in_ready_r;
  logic             in_ready_nx_s;
  logic             out_valid_r;
  logic             out_valid_nx_s;
  logic [ACC_W-1:0] acc_r;
  logic             ovf_r;
  logic [LEN_W-1:0] rem_r;

  logic             beat_s;
  logic             first_s;
  logic             single_s;
  logic [LEN_W-1:0] len_m1_s;
  logic [ACC_W-1:0] add_a_s;
  logic [ACC_W-1:0] sum_s;
  logic             carry_s;

  assign beat_s   = bus.in_valid & in_ready_r;
  assign first_s  = (state_r == IDLE);
  // len of 0 behaves as 1: both leave nothing remaining after the first beat
  assign single_s = (bus.len <= LEN_W'(1));
  assign len_m1_s = single_s ? {LEN_W{1'b0}} : (bus.len - LEN_W'(1));
  // the first beat of a group adds to zero, which also clears old overflow
  assign add_a_s  = first_s ? {ACC_W{1'b0}} : acc_r;

  mac_acc_add #(
    .ACC_W (ACC_W)
  ) u_add (
    .a     (add_a_s),
    .b     (bus.p_in),
    .sum   (sum_s),
    .carry (carry_s)
  );

  // state register and registered handshake outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      in_ready_r  <= in_ready_nx_s;
      out_valid_r <= out_valid_nx_s;
    end
  end

  // next-state selection; clr overrides every transition
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (beat_s) begin
          if (single_s) begin
            state_nx_s = HOLD;
          end else begin
            state_nx_s = ACCUM;
          end
        end else begin
          state_nx_s = IDLE;
        end
      end
      ACCUM: begin
        if (beat_s && (rem_r == LEN_W'(1))) begin
          state_nx_s = HOLD;
        end else begin
          state_nx_s = ACCUM;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = HOLD;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
    if (clr) begin
      state_nx_s = IDLE;
    end else begin
      state_nx_s = state_nx_s;
    end
  end

  // handshake outputs decoded from the next state so they register with it
  always_comb begin
    in_ready_nx_s  = 1'b1;
    out_valid_nx_s = 1'b0;
    case (state_nx_s)
      IDLE: begin
        in_ready_nx_s  = 1'b1;
        out_valid_nx_s = 1'b0;
      end
      ACCUM: begin
        in_ready_nx_s  = 1'b1;
        out_valid_nx_s = 1'b0;
      end
      HOLD: begin
        in_ready_nx_s  = 1'b0;
        out_valid_nx_s = 1'b1;
      end
      default: begin
        in_ready_nx_s  = 1'b1;
        out_valid_nx_s = 1'b0;
      end
    endcase
  end

  // accumulator, sticky overflow and remaining-beat counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_r <= {ACC_W{1'b0}};
      ovf_r <= 1'b0;
      rem_r <= {LEN_W{1'b0}};
    end else if (clr) begin
      acc_r <= {ACC_W{1'b0}};
      ovf_r <= 1'b0;
      rem_r <= {LEN_W{1'b0}};
    end else if (beat_s) begin
      acc_r <= sum_s;
      if (first_s) begin
        ovf_r <= carry_s;
        rem_r <= len_m1_s;
      end else begin
        ovf_r <= ovf_r | carry_s;
        rem_r <= rem_r - LEN_W'(1);
      end
    end else begin
      acc_r <= acc_r;
      ovf_r <= ovf_r;
      rem_r <= rem_r;
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.acc_out   = acc_r;
  assign bus.ovf       = ovf_r;

endmodule

// File: tb/tb_mac_accum.sv
// tb_mac_accum: randomized self-checking bench for mac_accum (ACC_W=20).
// Expected group results come from plain integer sums of the products fed.
module tb_mac_accum;

  localparam int    ACC_W   = 20;
  localparam int    LEN_W   = 8;
  localparam longint ACC_LIM = 64'd1 << ACC_W;

  logic clk;
  logic rst_n;
  logic clr;

  int errors = 0;
  int checks = 0;

  int     prods_q[$];
  longint exp_acc;
  logic   exp_ovf;

  mac_accum_if #(.ACC_W(ACC_W), .LEN_W(LEN_W)) bus ();

  mac_accum #(
    .ACC_W (ACC_W),
    .LEN_W (LEN_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // feed one group (with random bubbles and len changes after the first
  // beat) and check the first result cycle
  task automatic feed_group(input int raw_len);
    int     eff;
    int     idx;
    longint total;
    eff   = (raw_len == 0) ? 1 : raw_len;
    idx   = 0;
    total = 0;
    while (idx < eff) begin
      @(negedge clk);
      chk("busy_out_valid", 32'(bus.out_valid), 32'd0);
      chk("busy_in_ready", 32'(bus.in_ready), 32'd1);
      if (idx > 0) chk("partial_ovf", 32'(bus.ovf), 32'(total >= ACC_LIM));
      if (idx > 0 && $urandom_range(0, 3) == 0) begin
        bus.in_valid = 1'b0;
        bus.len      = 8'($urandom);
      end else begin
        bus.in_valid = 1'b1;
        bus.p_in     = 16'(prods_q[idx]);
        bus.len      = (idx == 0) ? 8'(raw_len) : 8'($urandom);
        total        = total + longint'(prods_q[idx]);
        idx++;
      end
    end
    exp_ovf = (total >= ACC_LIM);
`ifdef MAC_ACCUM_SAT_EN
    exp_acc = exp_ovf ? (ACC_LIM - 64'd1) : total;
`else
    exp_acc = total % ACC_LIM;
`endif
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("hold_out_valid", 32'(bus.out_valid), 32'd1);
    chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
    chk("hold_acc", 32'(bus.acc_out), 32'(exp_acc));
    chk("hold_ovf", 32'(bus.ovf), 32'(exp_ovf));
  endtask

  // keep the result held for 'hold' extra cycles while junk beats are
  // offered, then handshake and confirm return to IDLE
  task automatic drain_group(input int hold);
    bus.in_valid  = 1'b1;
    bus.p_in      = 16'($urandom);
    bus.out_ready = (hold == 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("held_out_valid", 32'(bus.out_valid), 32'd1);
      chk("held_in_ready", 32'(bus.in_ready), 32'd0);
      chk("held_acc", 32'(bus.acc_out), 32'(exp_acc));
      chk("held_ovf", 32'(bus.ovf), 32'(exp_ovf));
      bus.p_in = 16'($urandom);
      if (i == hold - 1) bus.out_ready = 1'b1;
    end
    @(negedge clk);
    chk("hs_out_valid", 32'(bus.out_valid), 32'd0);
    chk("hs_in_ready", 32'(bus.in_ready), 32'd1);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  task automatic fill_const(input int n, input int val);
    prods_q.delete();
    for (int i = 0; i < n; i++) prods_q.push_back(val);
  endtask

  initial begin
    int n;
    rst_n         = 1'b0;
    clr           = 1'b0;
    bus.len       = 8'd0;
    bus.p_in      = 16'd0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_acc", 32'(bus.acc_out), 32'd0);
    chk("rst_ovf", 32'(bus.ovf), 32'd0);

    // 1+2+3+4 with out_ready already high
    prods_q = '{1, 2, 3, 4};
    bus.out_ready = 1'b1;
    feed_group(4);
    chk("sum10", 32'(bus.acc_out), 32'd10);
    drain_group(0);

    // len 0 acts as len 1
    prods_q = '{65025};
    feed_group(0);
    chk("len0", 32'(bus.acc_out), 32'd65025);
    drain_group(2);

    // 17 x 65025 overflows 20 bits, then held 5 cycles
    fill_const(17, 65025);
    feed_group(17);
`ifdef MAC_ACCUM_SAT_EN
    chk("ovf_acc", 32'(bus.acc_out), 32'd1048575);
`else
    chk("ovf_acc", 32'(bus.acc_out), 32'd56849);
`endif
    chk("ovf_flag", 32'(bus.ovf), 32'd1);
    drain_group(5);

    // next group must start with overflow cleared
    prods_q = '{7, 9};
    feed_group(2);
    chk("ovf_cleared", 32'(bus.ovf), 32'd0);
    drain_group(1);

    // abort after 2 of 4 beats while a third beat is offered
    @(negedge clk);
    bus.in_valid = 1'b1; bus.len = 8'd4; bus.p_in = 16'd100;
    @(negedge clk);
    bus.p_in = 16'd200;
    @(negedge clk);
    clr = 1'b1; bus.p_in = 16'd300;
    @(negedge clk);
    chk("clr_out_valid", 32'(bus.out_valid), 32'd0);
    chk("clr_in_ready", 32'(bus.in_ready), 32'd1);
    chk("clr_acc", 32'(bus.acc_out), 32'd0);
    chk("clr_ovf", 32'(bus.ovf), 32'd0);
    clr = 1'b0; bus.in_valid = 1'b0;
    prods_q = '{5, 6};
    feed_group(2);
    chk("after_clr", 32'(bus.acc_out), 32'd11);
    drain_group(1);

    // random groups, occasionally large enough to overflow
    for (int g = 0; g < 30; g++) begin
      prods_q.delete();
      if ($urandom_range(0, 4) == 0) begin
        n = $urandom_range(15, 24);
        for (int i = 0; i < n; i++) prods_q.push_back($urandom_range(60000, 65025));
      end else begin
        n = $urandom_range(0, 7);
        for (int i = 0; i < ((n == 0) ? 1 : n); i++)
          prods_q.push_back($urandom_range(0, 255) * $urandom_range(0, 255));
      end
      feed_group(n);
      drain_group($urandom_range(0, 3));
    end

    // reset while a result is held
    fill_const(17, 65025);
    feed_group(17);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rsthold_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rsthold_acc", 32'(bus.acc_out), 32'd0);
    chk("rsthold_ovf", 32'(bus.ovf), 32'd0);
    chk("rsthold_in_ready", 32'(bus.in_ready), 32'd1);

    // a fresh group works after that reset
    prods_q = '{3, 4, 5};
    feed_group(3);
    chk("post_rst_sum", 32'(bus.acc_out), 32'd12);
    drain_group(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mac_accum.md
MAC_ACCUM -- requirements
Module: mac_accum

Interface
REQ-001 SHALL have parameter ACC_W, default 32, accumulator/result width (min 17).
REQ-002 SHALL have parameter LEN_W, default 8, width of group-length input.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port clr  input  1  synchronous abort of the current group.
REQ-006 SHALL have port len  input  LEN_W  products per group; sampled on the first beat only.
REQ-007 SHALL have port p_in  input  16  unsigned 8x8 product from the upstream multiplier.
REQ-008 SHALL have port in_valid  input  1  p_in valid.
REQ-009 SHALL have port in_ready  output  1  block can accept p_in.
REQ-010 SHALL have port acc_out  output  ACC_W  completed group sum.
REQ-011 SHALL have port ovf  output  1  group overflowed ACC_W; valid with out_valid.
REQ-012 SHALL have port out_valid  output  1  acc_out/ovf valid.
REQ-013 SHALL have port out_ready  input  1  downstream accepts result.

Function
REQ-014 SHALL implement states IDLE, ACCUM and HOLD.
REQ-015 SHALL accept a beat only when in_valid and in_ready are both 1 in the same cycle.
REQ-016 SHALL drive in_ready=1 in IDLE and ACCUM and in_ready=0 in HOLD.
REQ-017 On a beat in IDLE, SHALL load acc=zero-extended p_in, load remaining=len-1 and latch len; len==0 is treated as 1.
REQ-018 On a beat in ACCUM, SHALL set acc=acc+p_in and decrement remaining.
REQ-019 SHALL enter HOLD on the cycle after the beat that completes the group; IDLE->HOLD directly when effective len==1.
REQ-020 SHALL assert out_valid=1 exactly in HOLD, giving 1-cycle latency from the last accepted beat.
REQ-021 SHALL hold acc_out and ovf stable in HOLD until out_valid && out_ready, then return to IDLE.
REQ-022 SHALL never accept a beat in the out_ready handshake cycle; the next beat is taken in IDLE.
REQ-023 SHALL set ovf sticky when any addition carries out of ACC_W, and clear it on the first beat of a new group.
REQ-024 Without SAT_EN, SHALL keep the wrapped modulo-2^ACC_W sum on overflow.
REQ-025 SHALL make clr take priority over everything except rst_n: next state IDLE, out_valid=0, acc/ovf/remaining cleared, and any beat presented that cycle discarded.
REQ-026 SHALL ignore changes to len after the first beat of a group.

Reset
REQ-027 With rst_n=0 at a clock edge, SHALL enter IDLE with acc_out=0, ovf=0, out_valid=0, remaining=0, and in_ready=1 from the first cycle after release.
REQ-028 SHALL abandon any partial group or held result when reset is asserted mid-operation.

Configuration
REQ-029 With macro MAC_ACCUM_SAT_EN defined, SHALL clamp acc to all-ones on overflow, keep it there for the rest of the group, and still assert ovf.
REQ-030 Without MAC_ACCUM_SAT_EN, SHALL wrap per REQ-024 and contain no saturation logic.

Structure
REQ-031 SHALL place the state enum (IDLE/ACCUM/HOLD), the product width constant 16 and the default ACC_W/LEN_W in the shared MAC package.
REQ-032 SHALL implement add-with-carry-out and the optional clamp in one sub-module, mac_acc_add; the FSM and counter stay in mac_accum.

Verification
REQ-033 Bench SHALL check: len=4, products 1,2,3,4, out_ready=1 -> out_valid one cycle after the 4th beat, acc_out=10, ovf=0.
REQ-034 Bench SHALL check: len=0, single product 65025 -> treated as len 1, acc_out=65025.
REQ-035 Bench SHALL check: ACC_W=20, len=17, every product 65025 -> without SAT_EN acc_out=56849 and ovf=1; with SAT_EN acc_out=1048575 and ovf=1.
REQ-036 Bench SHALL check: result held with out_ready=0 for 5 cycles -> in_ready=0 and acc_out stable throughout; after the handshake, the next group starts with ovf=0.
REQ-037 Bench SHALL check: clr asserted after 2 of 4 beats, with in_valid=1 -> that beat is dropped, state IDLE, and the next group len=2 of 5,6 gives acc_out=11.
REQ-038 Bench SHALL check: rst_n low during HOLD -> out_valid=0, acc_out=0, in_ready=1 after release.
